fuzzy_inferencia: RTL and testbench

- Mamdani inference stage directly downstream of the rule-sequencing state machine.
- Consumes the 6-bit rule code stream that machine emits, one code per enabled clock.
- For each rule it looks up the antecedent membership degrees and computes the firing strength (min). It then max-aggregates that strength into one of five output-set accumulators.
- At end of frame it publishes the aggregated vector to the defuzzifier and pulses done.

---
 rtl/fuzzy_pkg.sv | 24 ++
 rtl/fuzzy_tnorm.sv | 31 +++
 rtl/fuzzy_inferencia.sv | 190 +++++++++++++++++++
 tb/tb_fuzzy_inferencia.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fuzzy_pkg.sv
// Shared definitions for the fuzzy inference stage: degree width, sequencer
// code constants, set counts, FSM state encoding and the consequent helper.
package fuzzy_pkg;

  localparam int W_DEF = 8;
  localparam int N_IN  = 3;
  localparam int N_OUT = 5;

  localparam logic [5:0] CODE_START = 6'b010000;
  localparam logic [5:0] CODE_END   = 6'b100000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Output set index for error set i and delta-error set j (NG..PG = 0..4).
  function automatic logic [2:0] consequent(input logic [1:0] i, input logic [1:0] j);
    return {1'b0, i} + {1'b0, j};
  endfunction

endpackage

// File: rtl/fuzzy_tnorm.sv
// Combinational t-norm for rule firing strength.
// Default build: minimum of the two degrees.
// With FUZZY_PROD_TNORM_EN defined: (a*b) >> W, truncated (algebraic product).
module fuzzy_tnorm import fuzzy_pkg::*; #(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

`ifdef FUZZY_PROD_TNORM_EN
  logic [2*W-1:0] prod_s;

  // Full-width product; the upper half is the scaled strength.
  always_comb begin
    prod_s = a * b;
    y      = W'(prod_s >> W);
  end
`else
  // Minimum of the two membership degrees.
  always_comb begin
    if (a < b) begin
      y = a;
    end else begin
      y = b;
    end
  end
`endif

endmodule

// File: rtl/fuzzy_inferencia.sv
// Mamdani inference stage fed by the rule sequencer. Per rule code it forms
// the firing strength of two antecedent degrees (stage 1) and max-merges it
// into one of five output-set accumulators (stage 2). END publishes the
// aggregate with a one-cycle done pulse. Optional build macro:
// FUZZY_PROD_TNORM_EN (product t-norm instead of min, see fuzzy_tnorm).
module fuzzy_inferencia import fuzzy_pkg::*; #(
  parameter int W = W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [5:0]           regra,
  input  logic [N_IN*W-1:0]    mu_e,
  input  logic [N_IN*W-1:0]    mu_de,
  output logic [N_OUT*W-1:0]   agg,
  output logic                 done,
  output logic [3:0]           rule_cnt,
  output logic                 busy
);

  state_t state_r;
  state_t state_s;

  logic                      is_start_s;
  logic                      is_end_s;
  logic                      is_rule_s;
  logic [1:0]                idx_e_s;
  logic [1:0]                idx_de_s;
  logic [W-1:0]              sel_e_s;
  logic [W-1:0]              sel_de_s;
  logic [W-1:0]              fire_s;

  logic                      clear_s;
  logic                      capture_s;
  logic                      publish_s;

  logic                      s1_valid_r;
  logic [W-1:0]              s1_fire_r;
  logic [2:0]                s1_k_r;

  logic [N_OUT-1:0][W-1:0]   acc_r;
  logic [3:0]                cnt_r;
  logic [N_OUT*W-1:0]        agg_r;
  logic [3:0]                rule_cnt_r;
  logic                      done_r;
  logic                      busy_r;

  // Decode the sequencer code; RULE needs both indices inside 0..2.
  always_comb begin
    idx_e_s    = regra[3:2];
    idx_de_s   = regra[1:0];
    is_start_s = (regra == CODE_START);
    is_end_s   = (regra == CODE_END);
    is_rule_s  = (regra[5:4] == 2'b00) && (idx_e_s != 2'd3) && (idx_de_s != 2'd3);
  end

  // Select the antecedent degrees addressed by the rule (index 3 never used).
  always_comb begin
    case (idx_e_s)
      2'd0:    sel_e_s = mu_e[0*W +: W];
      2'd1:    sel_e_s = mu_e[1*W +: W];
      2'd2:    sel_e_s = mu_e[2*W +: W];
      default: sel_e_s = {W{1'b0}};
    endcase
    case (idx_de_s)
      2'd0:    sel_de_s = mu_de[0*W +: W];
      2'd1:    sel_de_s = mu_de[1*W +: W];
      2'd2:    sel_de_s = mu_de[2*W +: W];
      default: sel_de_s = {W{1'b0}};
    endcase
  end

  fuzzy_tnorm #(.W(W)) u_tnorm (
    .a (sel_e_s),
    .b (sel_de_s),
    .y (fire_s)
  );

  // Next-state and datapath strobes; en=0 holds the FSM where it is.
  always_comb begin
    state_s   = state_r;
    clear_s   = 1'b0;
    capture_s = 1'b0;
    publish_s = 1'b0;
    if (en) begin
      case (state_r)
        IDLE: begin
          if (is_start_s) begin
            state_s = ACC;
            clear_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        ACC: begin
          if (is_start_s) begin
            clear_s = 1'b1;
          end else if (is_end_s) begin
            state_s = DRAIN;
          end else if (is_rule_s) begin
            capture_s = 1'b1;
          end else begin
            state_s = ACC;
          end
        end
        DRAIN: begin
          state_s = DONE;
        end
        DONE: begin
          state_s   = IDLE;
          publish_s = 1'b1;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Stage 1: capture firing strength and consequent; valid only for a sampled RULE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_r <= 1'b0;
      s1_fire_r  <= {W{1'b0}};
      s1_k_r     <= 3'd0;
    end else begin
      s1_valid_r <= capture_s;
      if (capture_s) begin
        s1_fire_r <= fire_s;
        s1_k_r    <= consequent(idx_e_s, idx_de_s);
      end
    end
  end

  // Stage 2 max-merge and rule count; a frame (re)start clear overrides the merge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r <= {(N_OUT*W){1'b0}};
      cnt_r <= 4'd0;
    end else if (clear_s) begin
      acc_r <= {(N_OUT*W){1'b0}};
      cnt_r <= 4'd0;
    end else begin
      for (int n = 0; n < N_OUT; n++) begin
        if (s1_valid_r && (s1_k_r == 3'(n)) && (s1_fire_r > acc_r[n])) begin
          acc_r[n] <= s1_fire_r;
        end
      end
      if (capture_s && (cnt_r != 4'd15)) begin
        cnt_r <= cnt_r + 4'd1;
      end
    end
  end

  // Registered outputs: publish on leaving DONE, busy spans START..done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      agg_r      <= {(N_OUT*W){1'b0}};
      rule_cnt_r <= 4'd0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      done_r <= publish_s;
      if (publish_s) begin
        agg_r      <= acc_r;
        rule_cnt_r <= cnt_r;
        busy_r     <= 1'b0;
      end else if (clear_s) begin
        busy_r <= 1'b1;
      end
    end
  end

  assign agg      = agg_r;
  assign rule_cnt = rule_cnt_r;
  assign done     = done_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_fuzzy_inferencia.sv
// Scoreboard bench for fuzzy_inferencia: directed frames from the test plan
// plus randomized frames, checked against a frame-level reference model.
module tb_fuzzy_inferencia;

  localparam int W = 8;

`ifdef FUZZY_PROD_TNORM_EN
  localparam logic [5*W-1:0] BASIC_AGG   = {8'd0, 8'd0, 8'd33, 8'd121, 8'd78};
  localparam logic [5*W-1:0] RESTART_AGG = {8'd0, 8'd0, 8'd33, 8'd0, 8'd0};
`else
  localparam logic [5*W-1:0] BASIC_AGG   = {8'd0, 8'd0, 8'd55, 8'd155, 8'd100};
  localparam logic [5*W-1:0] RESTART_AGG = {8'd0, 8'd0, 8'd55, 8'd0, 8'd0};
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [5:0]     regra;
  logic [3*W-1:0] mu_e;
  logic [3*W-1:0] mu_de;
  logic [5*W-1:0] agg;
  logic           done;
  logic [3:0]     rule_cnt;
  logic           busy;

  fuzzy_inferencia #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .regra    (regra),
    .mu_e     (mu_e),
    .mu_de    (mu_de),
    .agg      (agg),
    .done     (done),
    .rule_cnt (rule_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5*W-1:0] agg;
    logic [3:0]     cnt;
    int             cyc;
  } exp_t;

  exp_t sb[$];

  // Reference model state: one frame at a time.
  int me[3];
  int md[3];
  int m_acc[5];
  int m_cnt;
  bit m_in_frame;

  logic [5*W-1:0] last_pub = '0;
  logic           prev_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int tnorm(input int a, input int b);
`ifdef FUZZY_PROD_TNORM_EN
    return (a * b) / (1 << W);
`else
    return (a < b) ? a : b;
`endif
  endfunction

  function automatic logic [5*W-1:0] model_agg();
    logic [5*W-1:0] v;
    for (int k = 0; k < 5; k++) v[k*W +: W] = W'(m_acc[k]);
    return v;
  endfunction

  task automatic apply_mu();
    for (int i = 0; i < 3; i++) begin
      mu_e[i*W +: W]  = W'(me[i]);
      mu_de[i*W +: W] = W'(md[i]);
    end
  endtask

  // Apply the meaning of one sampled code to the frame model.
  task automatic model_step(input logic [5:0] c, input logic e, input int edge_no);
    int i, j;
    exp_t x;
    if (e) begin
      i = int'(c[3:2]);
      j = int'(c[1:0]);
      if (c == 6'b010000) begin
        for (int k = 0; k < 5; k++) m_acc[k] = 0;
        m_cnt = 0;
        m_in_frame = 1'b1;
      end else if (m_in_frame && c == 6'b100000) begin
        x.agg = model_agg();
        x.cnt = 4'(m_cnt);
        x.cyc = edge_no + 2;
        sb.push_back(x);
        m_in_frame = 1'b0;
      end else if (m_in_frame && c[5:4] == 2'b00 && i < 3 && j < 3) begin
        if (tnorm(me[i], md[j]) > m_acc[i + j]) m_acc[i + j] = tnorm(me[i], md[j]);
        if (m_cnt < 15) m_cnt++;
      end
    end
  endtask

  task automatic send(input logic [5:0] c, input logic e);
    regra = c;
    en    = e;
    @(posedge clk);
    #1;
    model_step(c, e, cyc);
  endtask

  task automatic fillers(input int n);
    for (int f = 0; f < n; f++) send(6'b111111, 1'b1);
  endtask

  task automatic shared_mu();
    me = '{200, 55, 0};
    md = '{100, 155, 0};
    apply_mu();
  endtask

  // Monitor: pop expectation on every done pulse, otherwise agg must hold.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      last_pub  = '0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        chk("done_width", prev_done, 1'b0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("agg", agg, e.agg);
          chk("rule_cnt", rule_cnt, e.cnt);
          chk("done_cycle", cyc, e.cyc);
          chk("busy_at_done", busy, 1'b0);
          last_pub = e.agg;
        end
      end else begin
        chk("agg_hold", agg, last_pub);
      end
      prev_done = done;
    end
  end

  initial begin
    logic [5:0] c;
    logic [5:0] prev_rule;
    int n, r;

    rst = 1'b0;
    en = 1'b0;
    regra = 6'b111111;
    m_in_frame = 1'b0;
    m_cnt = 0;
    for (int k = 0; k < 5; k++) m_acc[k] = 0;
    shared_mu();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_agg", agg, '0);
    chk("reset_rule_cnt", rule_cnt, '0);
    chk("reset_done", done, 1'b0);
    chk("reset_busy", busy, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame.
    send(6'b010000, 1'b1);
    chk("busy_after_start", busy, 1'b1);
    send(6'b000000, 1'b1);
    send(6'b000001, 1'b1);
    send(6'b000100, 1'b1);
    send(6'b000101, 1'b1);
    send(6'b100000, 1'b1);
    fillers(4);
    chk("basic_agg", agg, BASIC_AGG);
    chk("basic_cnt", rule_cnt, 4'd4);

    // Restart mid-frame.
    send(6'b010000, 1'b1);
    send(6'b000000, 1'b1);
    send(6'b000001, 1'b1);
    send(6'b010000, 1'b1);
    send(6'b000101, 1'b1);
    send(6'b100000, 1'b1);
    fillers(4);
    chk("restart_agg", agg, RESTART_AGG);
    chk("restart_cnt", rule_cnt, 4'd1);

    // Stall and invalid codes.
    send(6'b010000, 1'b1);
    send(6'b000000, 1'b1);
    send(6'b100000, 1'b0);
    send(6'b000110, 1'b0);
    send(6'b010000, 1'b0);
    send(6'b000011, 1'b1);
    send(6'b000001, 1'b1);
    send(6'b000100, 1'b1);
    send(6'b000101, 1'b1);
    send(6'b100000, 1'b1);
    fillers(4);
    chk("stall_agg", agg, BASIC_AGG);
    chk("stall_cnt", rule_cnt, 4'd4);

    // Repeated codes past the count saturation point.
    send(6'b010000, 1'b1);
    for (int q = 0; q < 18; q++) send(6'b000000, 1'b1);
    send(6'b100000, 1'b1);
    fillers(4);
    chk("sat_cnt", rule_cnt, 4'd15);

    // Empty frame.
    send(6'b010000, 1'b1);
    send(6'b100000, 1'b1);
    fillers(4);
    chk("empty_agg", agg, '0);
    chk("empty_cnt", rule_cnt, 4'd0);

    // Load a non-zero result, then abort a frame with async reset.
    send(6'b010000, 1'b1);
    send(6'b000000, 1'b1);
    send(6'b100000, 1'b1);
    fillers(4);
    send(6'b010000, 1'b1);
    send(6'b000000, 1'b1);
    send(6'b000001, 1'b1);
    rst = 1'b0;
    en = 1'b0;
    #1;
    chk("abort_agg", agg, '0);
    chk("abort_cnt", rule_cnt, '0);
    chk("abort_done", done, 1'b0);
    chk("abort_busy", busy, 1'b0);
    m_in_frame = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    fillers(4);

    // Next full frame after the abort.
    send(6'b010000, 1'b1);
    send(6'b000000, 1'b1);
    send(6'b000001, 1'b1);
    send(6'b000100, 1'b1);
    send(6'b000101, 1'b1);
    send(6'b100000, 1'b1);
    fillers(4);
    chk("post_reset_agg", agg, BASIC_AGG);

    // Randomized frames.
    prev_rule = 6'b000000;
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < 3; i++) begin
        me[i] = (f % 5 == 0) ? 255 : int'($urandom_range(0, 255));
        md[i] = int'($urandom_range(0, 255));
      end
      apply_mu();
      send(6'b010000, 1'b1);
      n = int'($urandom_range(0, 24));
      for (int s = 0; s < n; s++) begin
        r = int'($urandom_range(0, 99));
        if (r < 60) begin
          c = {2'b00, 2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
          prev_rule = c;
          send(c, 1'b1);
        end else if (r < 70) begin
          c = {2'b00, 2'd3, 2'($urandom_range(0, 3))};
          if (r[0]) c = {2'b00, 2'($urandom_range(0, 3)), 2'd3};
          send(c, 1'b1);
        end else if (r < 80) begin
          send(6'($urandom_range(0, 63)), 1'b0);
        end else if (r < 86) begin
          c = {2'($urandom_range(1, 3)), 4'($urandom_range(0, 15))};
          if (c[3:0] == 4'd0 && c[5:4] != 2'b11) c[0] = 1'b1;
          send(c, 1'b1);
        end else if (r < 94) begin
          send(prev_rule, 1'b1);
        end else begin
          send(6'b010000, 1'b1);
        end
      end
      send(6'b100000, 1'b1);
      fillers(4);
    end

    repeat (6) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
